// File: rtl/icm_mapping_table_if.sv
// Bus interface for icm_mapping_table: mapping-set write port, flush control,
// lookup request channel and lookup response channel.
//
// Handshake rules:
//   - lookup_valid/lookup_ready: a lookup is accepted on a rising clk edge
//     where both are high. The master holds lookup_icm_page stable while
//     lookup_valid is high and not yet accepted. A flush_req in the same
//     cycle pre-empts the lookup, so the master must not pulse flush_req
//     while it waits for acceptance.
//   - rsp_valid/rsp_ready: once rsp_valid rises, rsp_hit and rsp_phy_page
//     stay stable until the edge where rsp_ready is also high.
//   - mapping_set_valid has no ready. A write is taken unless a flush is
//     running or pending; in that case it is dropped and flagged.
interface icm_mapping_table_if #(
    parameter int PAGE_FRAME_WIDTH = 52
);
    logic                        mapping_set_valid;
    logic [PAGE_FRAME_WIDTH-1:0] mapping_set_head;
    logic [PAGE_FRAME_WIDTH-1:0] mapping_set_data;
    logic                        flush_req;
    logic                        flush_busy;
    logic                        lookup_valid;
    logic [PAGE_FRAME_WIDTH-1:0] lookup_icm_page;
    logic                        lookup_ready;
    logic                        rsp_valid;
    logic                        rsp_hit;
    logic [PAGE_FRAME_WIDTH-1:0] rsp_phy_page;
    logic                        rsp_ready;
    logic                        set_drop_err;

    modport master (
        output mapping_set_valid, mapping_set_head, mapping_set_data,
        output flush_req, lookup_valid, lookup_icm_page, rsp_ready,
        input  flush_busy, lookup_ready, rsp_valid, rsp_hit, rsp_phy_page,
        input  set_drop_err
    );

    modport slave (
        input  mapping_set_valid, mapping_set_head, mapping_set_data,
        input  flush_req, lookup_valid, lookup_icm_page, rsp_ready,
        output flush_busy, lookup_ready, rsp_valid, rsp_hit, rsp_phy_page,
        output set_drop_err
    );
endinterface

// File: rtl/icm_mapping_table.sv
// icm_mapping_table: direct-mapped ICM page frame -> physical page frame table.
// One write port (mapping set), one single-outstanding lookup channel with a
// 2-cycle response, and a walking flush that clears one valid bit per cycle.
// A flush walk also runs automatically after reset.
// Optional feature macro: ICM_MAP_STATS_EN adds saturating hit/miss/set
// counters, cleared at reset and whenever a flush walk starts.
module icm_mapping_table #(
    parameter int PAGE_FRAME_WIDTH = 52,
    parameter int INDEX_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    icm_mapping_table_if.slave    bus,
    output logic [1:0]            dbg_state
`ifdef ICM_MAP_STATS_EN
    ,
    output logic [31:0]           stat_hit_cnt,
    output logic [31:0]           stat_miss_cnt,
    output logic [31:0]           stat_set_cnt
`endif
);
    localparam int PFW     = PAGE_FRAME_WIDTH;
    localparam int IW      = INDEX_WIDTH;
    localparam int TW      = PFW - IW;
    localparam int ENTRIES = 1 << IW;
    localparam int EW      = TW + PFW;   // stored entry: {tag, phy_page}

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_RESP  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t          state_q;
    logic            flush_pend_q;
    logic [IW-1:0]   flush_ptr_q;
    logic            lookup_ready_q;
    logic            flush_busy_q;
    logic            rsp_valid_q;
    logic            rsp_hit_q;
    logic [PFW-1:0]  rsp_phy_q;
    logic            set_drop_err_q;
    logic [IW-1:0]   lk_idx_q;
    logic [TW-1:0]   lk_tag_q;

    // Tag/data storage (RAM-inferable) and the separate valid bit vector,
    // which must be clearable one entry per cycle by the flush walk.
    logic [EW-1:0]      mem [ENTRIES];
    logic [ENTRIES-1:0] valid_q;
    logic [EW-1:0]      rd_ent_q;
    logic               rd_valid_q;
    logic               fwd_q;
    logic [EW-1:0]      fwd_ent_q;

    logic [IW-1:0]  set_idx;
    logic [EW-1:0]  set_ent;
    logic           set_blocked;
    logic           set_accept;
    logic [IW-1:0]  lk_idx;
    logic [TW-1:0]  lk_tag;
    logic           lk_accept;
    logic           rsp_hs;
    logic           flush_start;
    logic           ent_valid;
    logic [EW-1:0]  ent;
    logic           ent_hit;

    assign set_idx     = bus.mapping_set_head[IW-1:0];
    assign set_ent     = {bus.mapping_set_head[PFW-1:IW], bus.mapping_set_data};
    assign set_blocked = (state_q == S_FLUSH) || flush_pend_q;
    assign set_accept  = bus.mapping_set_valid && !set_blocked;
    assign lk_idx      = bus.lookup_icm_page[IW-1:0];
    assign lk_tag      = bus.lookup_icm_page[PFW-1:IW];
    assign lk_accept   = (state_q == S_IDLE) && lookup_ready_q && bus.lookup_valid &&
                         !bus.flush_req && !flush_pend_q;
    assign rsp_hs      = (state_q == S_RESP) && bus.rsp_ready;
    assign flush_start = ((state_q == S_IDLE) || rsp_hs) && (bus.flush_req || flush_pend_q);

    // Resolve the entry seen by the READ-cycle compare: RAM read data, then a
    // write that landed on the accept edge, then a write landing right now.
    always_comb begin
        ent_valid = rd_valid_q;
        ent       = rd_ent_q;
        if (fwd_q) begin
            ent_valid = 1'b1;
            ent       = fwd_ent_q;
        end
        if (set_accept && (set_idx == lk_idx_q)) begin
            ent_valid = 1'b1;
            ent       = set_ent;
        end
    end

    assign ent_hit = ent_valid && (ent[EW-1:PFW] == lk_tag_q);

    // Tag/data RAM: one write port, one registered read port, plus capture of
    // a same-edge write to the looked-up index for write-first behaviour.
    always_ff @(posedge clk) begin
        if (set_accept) begin
            mem[set_idx] <= set_ent;
        end
        if (lk_accept) begin
            rd_ent_q  <= mem[lk_idx];
            fwd_q     <= set_accept && (set_idx == lk_idx);
            fwd_ent_q <= set_ent;
        end
    end

    // Valid bits: cleared by the flush walk, set by accepted writes.
    always_ff @(posedge clk) begin
        if (state_q == S_FLUSH) begin
            valid_q[flush_ptr_q] <= 1'b0;
        end else if (set_accept) begin
            valid_q[set_idx] <= 1'b1;
        end
        if (lk_accept) begin
            rd_valid_q <= valid_q[lk_idx];
        end
    end

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            flush_pend_q   <= 1'b1;   // post-reset walk clears the valid bits
            flush_ptr_q    <= '0;
            lookup_ready_q <= 1'b0;
            flush_busy_q   <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_hit_q      <= 1'b0;
            rsp_phy_q      <= '0;
            set_drop_err_q <= 1'b0;
            lk_idx_q       <= '0;
            lk_tag_q       <= '0;
        end else begin
            if (bus.mapping_set_valid && set_blocked) begin
                set_drop_err_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (flush_start) begin
                        state_q        <= S_FLUSH;
                        flush_busy_q   <= 1'b1;
                        lookup_ready_q <= 1'b0;
                        flush_pend_q   <= 1'b0;
                        flush_ptr_q    <= '0;
                    end else if (lk_accept) begin
                        state_q        <= S_READ;
                        lookup_ready_q <= 1'b0;
                        lk_idx_q       <= lk_idx;
                        lk_tag_q       <= lk_tag;
                    end
                end
                S_READ: begin
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_hit_q   <= ent_hit;
                    rsp_phy_q   <= ent_hit ? ent[PFW-1:0] : '0;
                    if (bus.flush_req) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= 1'b0;
                        rsp_hit_q   <= 1'b0;
                        rsp_phy_q   <= '0;
                        if (flush_start) begin
                            state_q      <= S_FLUSH;
                            flush_busy_q <= 1'b1;
                            flush_pend_q <= 1'b0;
                            flush_ptr_q  <= '0;
                        end else begin
                            state_q        <= S_IDLE;
                            lookup_ready_q <= 1'b1;
                        end
                    end else if (bus.flush_req) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    // Further flush requests here are merged into this walk.
                    flush_ptr_q <= flush_ptr_q + 1'b1;
                    if (flush_ptr_q == {IW{1'b1}}) begin
                        state_q        <= S_IDLE;
                        flush_busy_q   <= 1'b0;
                        lookup_ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef ICM_MAP_STATS_EN
    // Saturating statistics counters, zeroed at each flush start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hit_cnt  <= '0;
            stat_miss_cnt <= '0;
            stat_set_cnt  <= '0;
        end else if (flush_start) begin
            stat_hit_cnt  <= '0;
            stat_miss_cnt <= '0;
            stat_set_cnt  <= '0;
        end else begin
            if (rsp_hs && rsp_hit_q && (stat_hit_cnt != 32'hFFFF_FFFF)) begin
                stat_hit_cnt <= stat_hit_cnt + 32'd1;
            end
            if (rsp_hs && !rsp_hit_q && (stat_miss_cnt != 32'hFFFF_FFFF)) begin
                stat_miss_cnt <= stat_miss_cnt + 32'd1;
            end
            if (set_accept && (stat_set_cnt != 32'hFFFF_FFFF)) begin
                stat_set_cnt <= stat_set_cnt + 32'd1;
            end
        end
    end
`endif

    assign bus.flush_busy   = flush_busy_q;
    assign bus.lookup_ready = lookup_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_hit      = rsp_hit_q;
    assign bus.rsp_phy_page = rsp_phy_q;
    assign bus.set_drop_err = set_drop_err_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_icm_mapping_table.sv
// Testbench for icm_mapping_table: reset/flush timing, table-driven set and
// lookup vectors, forwarding corners, response hold with a deferred flush,
// dropped writes, randomized traffic against an associative-array model,
// and (with ICM_MAP_STATS_EN) the statistics counters.
module tb_icm_mapping_table;
    localparam int PFW = 52;
    localparam int IW  = 8;
    typedef logic [PFW-1:0] page_t;

    typedef struct {
        bit    is_set;
        page_t page;
        page_t data;
        bit    exp_hit;
        page_t exp_phy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg_state;
`ifdef ICM_MAP_STATS_EN
    logic [31:0] stat_hit_cnt;
    logic [31:0] stat_miss_cnt;
    logic [31:0] stat_set_cnt;
`endif

    icm_mapping_table_if #(.PAGE_FRAME_WIDTH(PFW)) bus ();

    icm_mapping_table #(
        .PAGE_FRAME_WIDTH(PFW),
        .INDEX_WIDTH(IW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .dbg_state(dbg_state)
`ifdef ICM_MAP_STATS_EN
        ,
        .stat_hit_cnt(stat_hit_cnt),
        .stat_miss_cnt(stat_miss_cnt),
        .stat_set_cnt(stat_set_cnt)
`endif
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Reference model: entry per index holding the full ICM page and data.
    page_t m_page [int];
    page_t m_data [int];
    int e_hit = 0;
    int e_miss = 0;
    int e_set = 0;
    logic [PFW:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PFW:0] model_rsp(input page_t page);
        int idx;
        idx = int'(page[IW-1:0]);
        if (m_page.exists(idx) && (m_page[idx] == page)) begin
            return {1'b1, m_data[idx]};
        end
        return '0;
    endfunction

    function automatic void model_set(input page_t head, input page_t data);
        m_page[int'(head[IW-1:0])] = head;
        m_data[int'(head[IW-1:0])] = data;
        e_set++;
    endfunction

    function automatic void model_flush();
        m_page.delete();
        m_data.delete();
        e_hit = 0;
        e_miss = 0;
        e_set = 0;
    endfunction

    // Driver tasks
    task automatic drive_set(input page_t head, input page_t data);
        @(negedge clk);
        bus.mapping_set_valid = 1'b1;
        bus.mapping_set_head  = head;
        bus.mapping_set_data  = data;
        model_set(head, data);
        @(negedge clk);
        bus.mapping_set_valid = 1'b0;
    endtask

    task automatic wait_lookup_ready();
        int guard = 0;
        while (!bus.lookup_ready && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.lookup_ready) check("lookup_ready_timeout", 64'(bus.lookup_ready), 64'd1);
    endtask

    // Ends at the negedge after the accept edge.
    task automatic issue_lookup(input page_t page);
        @(negedge clk);
        bus.lookup_valid    = 1'b1;
        bus.lookup_icm_page = page;
        wait_lookup_ready();
        exp_q.push_back(model_rsp(page));
        @(negedge clk);
        bus.lookup_valid = 1'b0;
    endtask

    // lat = negedges already elapsed since the accept edge.
    task automatic collect_rsp(input int start_lat, output logic hit, output page_t phy);
        int lat;
        logic [PFW:0] exp;
        lat = start_lat;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", 64'(lat), 64'd2);
        hit = bus.rsp_hit;
        phy = bus.rsp_phy_page;
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 64'd0, 64'd1);
        end else begin
            exp = exp_q.pop_front();
            check("rsp_hit", 64'(hit), 64'(exp[PFW]));
            check("rsp_phy_page", 64'(phy), 64'(exp[PFW-1:0]));
            if (exp[PFW]) e_hit++;
            else e_miss++;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_valid_after_hs", 64'(bus.rsp_valid), 64'd0);
    endtask

    task automatic do_lookup(input page_t page, output logic hit, output page_t phy);
        issue_lookup(page);
        collect_rsp(1, hit, phy);
    endtask

    // Called at a negedge where flush_busy is expected high.
    task automatic wait_flush(output int cnt, output bit ready_seen);
        int guard = 0;
        cnt = 0;
        ready_seen = 1'b0;
        while (bus.flush_busy && guard < 1000) begin
            cnt++;
            if (bus.lookup_ready) ready_seen = 1'b1;
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic do_flush();
        int cnt;
        bit rs;
        @(negedge clk);
        bus.flush_req = 1'b1;
        model_flush();
        @(posedge clk);
        #1 bus.flush_req = 1'b0;
        @(negedge clk);
        wait_flush(cnt, rs);
        check("flush_len", 64'(cnt), 64'd256);
    endtask

`ifdef ICM_MAP_STATS_EN
    task automatic check_stats(input string tag);
        check({tag, "_hit_cnt"}, 64'(stat_hit_cnt), 64'(e_hit));
        check({tag, "_miss_cnt"}, 64'(stat_miss_cnt), 64'(e_miss));
        check({tag, "_set_cnt"}, 64'(stat_set_cnt), 64'(e_set));
    endtask
`endif

    // Main sequence
    initial begin
        vec_t  vecs [11];
        int    cnt;
        int    cnt2;
        bit    rs;
        logic  hit;
        logic  hit0;
        page_t phy;
        page_t phy0;
        page_t pp;
        logic [63:0] rnd;
        logic [PFW:0] exp;

        vecs[0]  = '{1'b1, 52'h00001_0005, 52'h000000_00ABCDE, 1'b0, 52'h0};
        vecs[1]  = '{1'b0, 52'h00001_0005, 52'h0, 1'b1, 52'hABCDE};
        vecs[2]  = '{1'b0, 52'h00002_0005, 52'h0, 1'b0, 52'h0};
        vecs[3]  = '{1'b1, 52'h000FF, 52'h1, 1'b0, 52'h0};
        vecs[4]  = '{1'b0, 52'h000FF, 52'h0, 1'b1, 52'h1};
        vecs[5]  = '{1'b1, 52'h700FF, 52'hF_FFFF_FFFF_FFFF, 1'b0, 52'h0};
        vecs[6]  = '{1'b0, 52'h000FF, 52'h0, 1'b0, 52'h0};
        vecs[7]  = '{1'b0, 52'h700FF, 52'h0, 1'b1, 52'hF_FFFF_FFFF_FFFF};
        vecs[8]  = '{1'b1, 52'hF_FFFF_FFFF_FF00, 52'h42, 1'b0, 52'h0};
        vecs[9]  = '{1'b0, 52'hF_FFFF_FFFF_FF00, 52'h0, 1'b1, 52'h42};
        vecs[10] = '{1'b0, 52'h0, 52'h0, 1'b0, 52'h0};

        bus.mapping_set_valid = 1'b0;
        bus.mapping_set_head  = '0;
        bus.mapping_set_data  = '0;
        bus.flush_req         = 1'b0;
        bus.lookup_valid      = 1'b0;
        bus.lookup_icm_page   = '0;
        bus.rsp_ready         = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_flush_busy", 64'(bus.flush_busy), 64'd0);
        check("reset_lookup_ready", 64'(bus.lookup_ready), 64'd0);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_rsp_hit", 64'(bus.rsp_hit), 64'd0);
        check("reset_rsp_phy", 64'(bus.rsp_phy_page), 64'd0);
        check("reset_drop_err", 64'(bus.set_drop_err), 64'd0);
        check("reset_dbg_state", 64'(dbg_state), 64'd0);
`ifdef ICM_MAP_STATS_EN
        check_stats("reset");
`endif
        rst_n = 1'b1;

        // Post-reset flush walk
        @(negedge clk);
        wait_flush(cnt, rs);
        check("post_reset_flush_len", 64'(cnt), 64'd256);
        check("ready_during_flush", 64'(rs), 64'd0);
        check("ready_after_flush", 64'(bus.lookup_ready), 64'd1);
        do_lookup(52'h123, hit, phy);
        check("post_reset_miss_hit", 64'(hit), 64'd0);
        check("post_reset_miss_phy", 64'(phy), 64'd0);

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_set) begin
                drive_set(vecs[i].page, vecs[i].data);
            end else begin
                do_lookup(vecs[i].page, hit, phy);
                check($sformatf("vec%0d_hit", i), 64'(hit), 64'(vecs[i].exp_hit));
                check($sformatf("vec%0d_phy", i), 64'(phy), 64'(vecs[i].exp_phy));
            end
        end

        // Write to the same page on the lookup accept edge
        @(negedge clk);
        bus.lookup_valid    = 1'b1;
        bus.lookup_icm_page = 52'h00001_0005;
        wait_lookup_ready();
        bus.mapping_set_valid = 1'b1;
        bus.mapping_set_head  = 52'h00001_0005;
        bus.mapping_set_data  = 52'h12345;
        model_set(52'h00001_0005, 52'h12345);
        exp_q.push_back({1'b1, 52'h12345});
        @(negedge clk);
        bus.lookup_valid      = 1'b0;
        bus.mapping_set_valid = 1'b0;
        collect_rsp(1, hit, phy);
        check("fwd_accept_phy", 64'(phy), 64'h12345);

        // Write to the same page during the READ cycle
        @(negedge clk);
        bus.lookup_valid    = 1'b1;
        bus.lookup_icm_page = 52'h00001_0005;
        wait_lookup_ready();
        @(negedge clk);
        bus.lookup_valid      = 1'b0;
        bus.mapping_set_valid = 1'b1;
        bus.mapping_set_head  = 52'h00001_0005;
        bus.mapping_set_data  = 52'h55555;
        model_set(52'h00001_0005, 52'h55555);
        exp_q.push_back({1'b1, 52'h55555});
        @(negedge clk);
        bus.mapping_set_valid = 1'b0;
        collect_rsp(2, hit, phy);
        check("fwd_read_phy", 64'(phy), 64'h55555);
        do_lookup(52'h00001_0005, hit, phy);
        check("fwd_persist_phy", 64'(phy), 64'h55555);

        // Randomized traffic over a small index/tag space
        for (int i = 0; i < 80; i++) begin
            pp = (page_t'($urandom_range(0, 3)) << IW) | page_t'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                rnd = {$urandom(), $urandom()};
                drive_set(pp, rnd[PFW-1:0]);
            end else begin
                do_lookup(pp, hit, phy);
            end
        end
`ifdef ICM_MAP_STATS_EN
        check_stats("random");
`endif

        // Hold response, flush requested while held
        issue_lookup(52'h00001_0005);
        cnt2 = 1;
        while (!bus.rsp_valid && cnt2 < 20) begin
            @(negedge clk);
            cnt2++;
        end
        check("hold_latency", 64'(cnt2), 64'd2);
        hit0 = bus.rsp_hit;
        phy0 = bus.rsp_phy_page;
        exp = exp_q.pop_front();
        check("hold_hit", 64'(hit0), 64'(exp[PFW]));
        check("hold_phy", 64'(phy0), 64'(exp[PFW-1:0]));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.flush_req = (k == 1);
            check($sformatf("hold%0d_valid", k), 64'(bus.rsp_valid), 64'd1);
            check($sformatf("hold%0d_phy", k), 64'(bus.rsp_phy_page), 64'(phy0));
            check($sformatf("hold%0d_hit", k), 64'(bus.rsp_hit), 64'(hit0));
            check($sformatf("hold%0d_lookup_ready", k), 64'(bus.lookup_ready), 64'd0);
            check($sformatf("hold%0d_flush_busy", k), 64'(bus.flush_busy), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        model_flush();
        check("flush_after_hs_busy", 64'(bus.flush_busy), 64'd1);
        check("flush_after_hs_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("drop_err_before", 64'(bus.set_drop_err), 64'd0);
        // Set during flush: must be dropped and flagged
        bus.mapping_set_valid = 1'b1;
        bus.mapping_set_head  = 52'h00003_0007;
        bus.mapping_set_data  = 52'h77777;
        @(negedge clk);
        bus.mapping_set_valid = 1'b0;
        check("drop_err_set", 64'(bus.set_drop_err), 64'd1);
        wait_flush(cnt, rs);
        check("deferred_flush_len", 64'(cnt + 1), 64'd256);
        check("ready_during_deferred_flush", 64'(rs), 64'd0);
        do_lookup(52'h00003_0007, hit, phy);
        check("dropped_entry_hit", 64'(hit), 64'd0);
        do_lookup(52'h00001_0005, hit, phy);
        check("flushed_entry_hit", 64'(hit), 64'd0);
        check("drop_err_sticky", 64'(bus.set_drop_err), 64'd1);
`ifdef ICM_MAP_STATS_EN
        check_stats("post_flush");
`endif

        // Statistics: 3 sets, 2 hits, 1 miss, then flush clears
        do_flush();
        drive_set(52'h00010_0001, 52'h1001);
        drive_set(52'h00010_0002, 52'h1002);
        drive_set(52'h00010_0003, 52'h1003);
        do_lookup(52'h00010_0001, hit, phy);
        do_lookup(52'h00010_0003, hit, phy);
        do_lookup(52'h00020_0002, hit, phy);
        check("stats_seq_hit_model", 64'(e_hit), 64'd2);
`ifdef ICM_MAP_STATS_EN
        check("stat_hit_3_2_1", 64'(stat_hit_cnt), 64'd2);
        check("stat_miss_3_2_1", 64'(stat_miss_cnt), 64'd1);
        check("stat_set_3_2_1", 64'(stat_set_cnt), 64'd3);
`endif
        do_flush();
`ifdef ICM_MAP_STATS_EN
        check("stat_hit_cleared", 64'(stat_hit_cnt), 64'd0);
        check("stat_miss_cleared", 64'(stat_miss_cnt), 64'd0);
        check("stat_set_cleared", 64'(stat_set_cnt), 64'd0);
`endif
        do_lookup(52'h00010_0001, hit, phy);
        check("final_flushed_hit", 64'(hit), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
